// File: rtl/dpram_be_v2.sv
// dpram_be_v2: true dual-port RAM with byte strobes on both ports, 1 or 2 cycle
// read latency, read-first / no-change write mode, a post-reset clear
// sequencer and same-address collision flag.

package dpram_be_v2_pkg;
    // Address width helper shared with the older memories.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

module dpram_be_v2 import dpram_be_v2_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2048,
    parameter int OUT_REG = 0,
    parameter int WRITE_MODE = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int NB = DATA_WIDTH / 8,
    localparam int AW = clogb2(DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [NB-1:0]         wema,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [NB-1:0]         wemb,
    input  logic [AW-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  init_busy,
    output logic                  collision
);

    typedef enum logic {CLEAR, READY} st_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    st_t                   st, st_nxt;
    logic [AW-1:0]         cnt;
    logic                  acc_a, acc_b, wr_a, wr_b;
    logic                  acc_a_d, acc_b_d;
    logic [DATA_WIDTH-1:0] s1_a, s1_b, s2_a, s2_b;

    // A port only acts once the clear sequencer has released the array.
    assign acc_a = ena & ~init_busy & ~rst;
    assign acc_b = enb & ~init_busy & ~rst;
    assign wr_a  = acc_a & wea & (|wema);
    assign wr_b  = acc_b & web & (|wemb);

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) st <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        else     st <= st_nxt;
    end

    // Clear sequencer next state: leave CLEAR after the last word is written.
    always_comb begin
        st_nxt = st;
        if (st == CLEAR && cnt == AW'(DEPTH - 1)) st_nxt = READY;
    end

    // Clear sequencer output.
    always_comb begin
        init_busy = (st == CLEAR);
    end

    // Clear address counter.
    always_ff @(posedge clk) begin
        if (rst)                    cnt <= '0;
        else if (st == CLEAR) begin
            if (cnt == AW'(DEPTH - 1)) cnt <= '0;
            else                       cnt <= cnt + 1'b1;
        end
    end

    // Array writes: clear fill, else byte-strobed writes with B applied last so
    // it wins on lanes both ports strobe at the same address.
    always_ff @(posedge clk) begin
        if (!rst && st == CLEAR) begin
            mem[cnt] <= CLEAR_VALUE;
        end else begin
            if (wr_a)
                for (int i = 0; i < NB; i++)
                    if (wema[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
            if (wr_b)
                for (int i = 0; i < NB; i++)
                    if (wemb[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        end
    end

    // Stage-1 read registers see the pre-edge array, so a write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a <= '0;
            s1_b <= '0;
        end else begin
            if (acc_a && !(wr_a && WRITE_MODE == 1)) s1_a <= mem[addra];
            if (acc_b && !(wr_b && WRITE_MODE == 1)) s1_b <= mem[addrb];
        end
    end

    // Optional stage 2 follows stage 1 one edge after each accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_a_d <= 1'b0;
            acc_b_d <= 1'b0;
            s2_a    <= '0;
            s2_b    <= '0;
        end else begin
            acc_a_d <= acc_a;
            acc_b_d <= acc_b;
            if (acc_a_d) s2_a <= s1_a;
            if (acc_b_d) s2_b <= s1_b;
        end
    end

    assign douta = (OUT_REG != 0) ? s2_a : s1_a;
    assign doutb = (OUT_REG != 0) ? s2_b : s1_b;

    // Collision pulse: both ports on one address with at least one write.
    always_ff @(posedge clk) begin
        if (rst) collision <= 1'b0;
        else     collision <= acc_a & acc_b & (addra == addrb) & (wr_a | wr_b);
    end

endmodule

// File: tb/tb_dpram_be_v2.sv
// Bench for dpram_be_v2: two instances share the stimulus, one read-first with
// single-cycle latency, one no-change with the output register.

module tb_dpram_be_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, wea, enb, web;
    logic [3:0]  wema, wemb, addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] douta0, doutb0, douta1, doutb1;
    logic        busy0, busy1, col0, col1;

    always #5 clk = ~clk;

    dpram_be_v2 #(.DATA_WIDTH(32), .DEPTH(16), .OUT_REG(0), .WRITE_MODE(0),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hDEADBEEF)) d0 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .wema(wema), .addra(addra), .dina(dina), .douta(douta0),
        .enb(enb), .web(web), .wemb(wemb), .addrb(addrb), .dinb(dinb), .doutb(doutb0),
        .init_busy(busy0), .collision(col0));

    dpram_be_v2 #(.DATA_WIDTH(32), .DEPTH(16), .OUT_REG(1), .WRITE_MODE(1),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hDEADBEEF)) d1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .wema(wema), .addra(addra), .dina(dina), .douta(douta1),
        .enb(enb), .web(web), .wemb(wemb), .addrb(addrb), .dinb(dinb), .doutb(doutb1),
        .init_busy(busy1), .collision(col1));

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [16];
    logic [31:0] s1 [2][2];
    string       nm [6] = '{"douta_rf", "doutb_rf", "douta_nc", "doutb_nc", "coll_rf", "coll_nc"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int idx);
        case (idx)
            0: return douta0;
            1: return doutb0;
            2: return douta1;
            3: return doutb1;
            4: return {31'd0, col0};
            default: return {31'd0, col1};
        endcase
    endfunction

    // Scoreboard: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                n_chk++;
                if (pick(sb[i].idx) !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d actual=%h expected=%h",
                             nm[sb[i].idx], cyc, pick(sb[i].idx), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    function automatic void push(input int due, input int idx, input logic [31:0] exp);
        sb_t e;
        e.due = due;
        e.idx = idx;
        e.exp = exp;
        sb.push_back(e);
    endfunction

    // One clock of traffic in READY; model updated, expectations queued.
    task automatic step(input logic ea, input logic wa, input logic [3:0] ma,
                        input logic [3:0] aa, input logic [31:0] da,
                        input logic eb, input logic wb, input logic [3:0] mb,
                        input logic [3:0] ab, input logic [31:0] db);
        logic [31:0] oa, ob;
        logic        wra, wrb, ce;
        ena = ea; wea = wa; wema = ma; addra = aa; dina = da;
        enb = eb; web = wb; wemb = mb; addrb = ab; dinb = db;
        oa  = mem_m[aa];
        ob  = mem_m[ab];
        wra = ea && wa && (ma != 4'd0);
        wrb = eb && wb && (mb != 4'd0);
        if (ea) s1[0][0] = oa;
        if (eb) s1[0][1] = ob;
        if (ea && !wra) s1[1][0] = oa;
        if (eb && !wrb) s1[1][1] = ob;
        ce = ea && eb && (aa == ab) && (wra || wrb);
        if (wra) for (int i = 0; i < 4; i++) if (ma[i]) mem_m[aa][8*i +: 8] = da[8*i +: 8];
        if (wrb) for (int i = 0; i < 4; i++) if (mb[i]) mem_m[ab][8*i +: 8] = db[8*i +: 8];
        @(posedge clk); #1;
        push(cyc,     0, s1[0][0]);
        push(cyc,     1, s1[0][1]);
        push(cyc + 1, 2, s1[1][0]);
        push(cyc + 1, 3, s1[1][1]);
        push(cyc,     4, {31'd0, ce});
        push(cyc,     5, {31'd0, ce});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 0; wea = 0; wema = 0; addra = 0; dina = 0;
        enb = 0; web = 0; wemb = 0; addrb = 0; dinb = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (douta0 !== 32'd0) begin n_fail++; $display("FAIL rst_douta_rf actual=%h expected=0", douta0); end
        n_chk++; if (doutb0 !== 32'd0) begin n_fail++; $display("FAIL rst_doutb_rf actual=%h expected=0", doutb0); end
        n_chk++; if (douta1 !== 32'd0) begin n_fail++; $display("FAIL rst_douta_nc actual=%h expected=0", douta1); end
        n_chk++; if (doutb1 !== 32'd0) begin n_fail++; $display("FAIL rst_doutb_nc actual=%h expected=0", doutb1); end
        n_chk++; if (col0 !== 1'b0 || col1 !== 1'b0) begin n_fail++; $display("FAIL rst_collision actual=%b%b expected=00", col0, col1); end
        n_chk++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_fail++; $display("FAIL rst_init_busy actual=%b%b expected=11", busy0, busy1); end
    endtask

    // Count cycles with init_busy high starting from the cycle rst is released.
    task automatic count_busy(input string tag);
        int c0, c1, guard;
        c0 = 0; c1 = 0; guard = 0;
        while ((busy0 === 1'b1 || busy1 === 1'b1) && guard < 100) begin
            if (busy0 === 1'b1) c0++;
            if (busy1 === 1'b1) c1++;
            guard++;
            @(posedge clk); #1;
        end
        n_chk++; if (c0 != 16) begin n_fail++; $display("FAIL %s_busy_rf actual=%0d expected=16", tag, c0); end
        n_chk++; if (c1 != 16) begin n_fail++; $display("FAIL %s_busy_nc actual=%0d expected=16", tag, c1); end
    endtask

    task automatic test_clear();
        rst = 1'b0;
        count_busy("clear");
        // Second clear, interrupted by rst five cycles in.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL midclear_busy actual=%b expected=1", busy0); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy("reclear");
        for (int i = 0; i < 16; i++) mem_m[i] = 32'hDEADBEEF;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) s1[d][p] = 32'd0;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 4'(i), 0, 1, 0, 0, 4'(15 - i), 0);
    endtask

    task automatic test_byte_strobe();
        step(1, 1, 4'b1111, 4'd3, 32'h11223344, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 4'b0101, 4'd3, 32'hAABBCCDD);
        step(1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
        idle(1);
        n_chk++; if (douta0 !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe_word actual=%h expected=11bb33dd", douta0); end
    endtask

    task automatic test_collision();
        step(1, 1, 4'b1111, 4'd7, 32'h0, 0, 0, 0, 0, 0);
        step(1, 1, 4'b0011, 4'd7, 32'h0000FFFF, 1, 1, 4'b0110, 4'd7, 32'h12345678);
        idle(2);
        step(1, 0, 0, 4'd7, 0, 1, 0, 0, 4'd7, 0);
        // Read against write on the same address also flags, reader sees old word.
        step(1, 0, 0, 4'd7, 0, 1, 1, 4'b1000, 4'd7, 32'hAA000000);
        idle(1);
        step(1, 0, 0, 4'd7, 0, 0, 0, 0, 0, 0);
        idle(1);
    endtask

    task automatic test_write_mode();
        step(1, 1, 4'b1111, 4'd2, 32'h5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 4'd3, 0);
        step(0, 0, 0, 0, 0, 1, 1, 4'b1111, 4'd2, 32'h9);
        step(0, 0, 0, 0, 0, 1, 0, 0, 4'd2, 0);
        idle(2);
    endtask

    task automatic test_latency();
        step(1, 1, 4'b1111, 4'd0, 32'd10, 0, 0, 0, 0, 0);
        step(1, 1, 4'b1111, 4'd1, 32'd11, 0, 0, 0, 0, 0);
        step(1, 1, 4'b1111, 4'd2, 32'd12, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4'd1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4'd2, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 4'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 4'($urandom_range(0, 3)), $urandom);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_strobe();
        test_collision();
        test_write_mode();
        test_latency();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d expected=0 pending", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
